// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory unit: access-size encodings,
// the request FSM state type and the wait-counter type.
package dmem_pkg;

   // Access size encodings carried on req_size
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   // Request handling FSM
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_t;

   // Access latency counter, covers WAIT_CYCLES 0..15
   typedef logic [3:0] wait_cnt_t;

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bus between the core memory stage (master) and the
// data memory unit (slave). Both directions use a valid/ready handshake.
interface data_mem_unit_if #(
   parameter int ADDR_W = 5
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the big-endian data memory.
// Lane k addresses byte addr+k; lane 0 is the most significant byte.
// Produces per-lane addresses, byte enables, store bytes, the extended
// load result and the request error flag.
// Macro DMEM_ALIGN_CHECK_EN: when defined, misaligned half/word accesses
// are errors; otherwise the low address bits are forced to zero.
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic [1:0]             size,
   input  logic                   is_signed,
   input  logic [ADDR_W-1:0]      addr,
   input  logic [31:0]            wdata,
   input  logic [3:0][7:0]        rd_bytes,
   output logic [3:0][ADDR_W-1:0] lane_addr,
   output logic [3:0]             byte_en,
   output logic [3:0][7:0]        wr_bytes,
   output logic [31:0]            load_data,
   output logic                   err
);

   logic [ADDR_W-1:0] base;

   function automatic logic [31:0] extend8(input logic [7:0] b, input logic sgn);
      return sgn ? {{24{b[7]}}, b} : {24'h0, b};
   endfunction

   function automatic logic [31:0] extend16(input logic [15:0] h, input logic sgn);
      return sgn ? {{16{h[15]}}, h} : {16'h0, h};
   endfunction

   // Effective base address, error detection, lane addresses, enables and store bytes
   always_comb begin
      base     = addr;
      err      = 1'b0;
      byte_en  = 4'b0000;
      wr_bytes = '0;
      case (size)
         SZ_BYTE: begin
            byte_en     = 4'b0001;
            wr_bytes[0] = wdata[7:0];
         end
         SZ_HALF: begin
`ifdef DMEM_ALIGN_CHECK_EN
            err = addr[0];
`else
            base[0] = 1'b0;
`endif
            byte_en     = 4'b0011;
            wr_bytes[0] = wdata[15:8];
            wr_bytes[1] = wdata[7:0];
         end
         SZ_WORD: begin
`ifdef DMEM_ALIGN_CHECK_EN
            err = (addr[1:0] != 2'b00);
`else
            base[1:0] = 2'b00;
`endif
            byte_en     = 4'b1111;
            wr_bytes[0] = wdata[31:24];
            wr_bytes[1] = wdata[23:16];
            wr_bytes[2] = wdata[15:8];
            wr_bytes[3] = wdata[7:0];
         end
         default: err = 1'b1;
      endcase
      if (err) byte_en = 4'b0000;
      for (int k = 0; k < 4; k++) lane_addr[k] = base + ADDR_W'(k);
   end

   // Load extraction: lowest address is most significant, then extend
   always_comb begin
      load_data = '0;
      case (size)
         SZ_BYTE: load_data = extend8(rd_bytes[0], is_signed);
         SZ_HALF: load_data = extend16({rd_bytes[0], rd_bytes[1]}, is_signed);
         SZ_WORD: load_data = {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]};
         default: load_data = '0;
      endcase
      if (err) load_data = '0;
   end

endmodule

// File: rtl/data_mem_unit.sv
// Byte-addressed, big-endian data memory with a valid/ready request and
// response handshake and WAIT_CYCLES of extra access latency.
// Accepts one request in IDLE, counts down in BUSY, commits the access on
// the last BUSY cycle and holds the response in RESP until taken.
// Macro DMEM_ALIGN_CHECK_EN (used in dmem_lane_align) selects alignment
// error reporting instead of silent address truncation.
module data_mem_unit
   import dmem_pkg::*;
#(
   parameter int    DEPTH       = 32,
   parameter int    ADDR_W      = $clog2(DEPTH),
   parameter int    WAIT_CYCLES = 0,
   parameter string INIT_FILE   = ""
) (
   input  logic           clk,
   input  logic           reset,
   data_mem_unit_if.slave bus
);

   dmem_state_t state, next_state;
   wait_cnt_t   cnt;

   // latched request
   logic              we_p0;
   logic [1:0]        size_p0;
   logic              signed_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [31:0]       wdata_p0;

   // response registers
   logic [31:0] rdata_q;
   logic        err_q;

   logic [7:0] mem [DEPTH];

   logic [3:0][ADDR_W-1:0] lane_addr;
   logic [3:0]             byte_en;
   logic [3:0][7:0]        wr_bytes;
   logic [3:0][7:0]        rd_bytes;
   logic [31:0]            load_data;
   logic                   lane_err;

   logic accept;
   logic commit;

   assign accept = (state == ST_IDLE) && bus.req_valid;
   assign commit = (state == ST_BUSY) && (cnt == '0);

   assign bus.req_ready = (state == ST_IDLE) && !reset;
   assign bus.rsp_valid = (state == ST_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

   dmem_lane_align #(
      .ADDR_W (ADDR_W)
   ) u_lane_align (
      .size      (size_p0),
      .is_signed (signed_p0),
      .addr      (addr_p0),
      .wdata     (wdata_p0),
      .rd_bytes  (rd_bytes),
      .lane_addr (lane_addr),
      .byte_en   (byte_en),
      .wr_bytes  (wr_bytes),
      .load_data (load_data),
      .err       (lane_err)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // FSM next-state logic
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (bus.req_valid)    next_state = ST_BUSY;
         ST_BUSY: if (cnt == '0)        next_state = ST_RESP;
         ST_RESP: if (bus.rsp_ready)    next_state = ST_IDLE;
         default:                       next_state = ST_IDLE;
      endcase
   end

   // Access latency counter: loaded on accept, decremented while busy
   always_ff @(posedge clk) begin
      if (reset)                                cnt <= '0;
      else if (accept)                          cnt <= wait_cnt_t'(WAIT_CYCLES);
      else if (state == ST_BUSY && cnt != '0)   cnt <= cnt - 1'b1;
   end

   // Capture the request fields; they stay stable for the whole access
   always_ff @(posedge clk) begin
      if (accept) begin
         we_p0     <= bus.req_we;
         size_p0   <= bus.req_size;
         signed_p0 <= bus.req_signed;
         addr_p0   <= bus.req_addr;
         wdata_p0  <= bus.req_wdata;
      end
   end

   // Asynchronous read of the four candidate lanes
   always_comb begin
      for (int k = 0; k < 4; k++) rd_bytes[k] = mem[lane_addr[k]];
   end

   // Store commit; reset during BUSY abandons the write, array is never cleared
   always_ff @(posedge clk) begin
      if (!reset && commit && we_p0 && !lane_err) begin
         for (int k = 0; k < 4; k++) begin
            if (byte_en[k]) mem[lane_addr[k]] <= wr_bytes[k];
         end
      end
   end

   // Response registers: loaded at commit, error cleared when the response is taken
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (commit) begin
         rdata_q <= (we_p0 || lane_err) ? 32'h0 : load_data;
         err_q   <= lane_err;
      end else if (state == ST_RESP && bus.rsp_ready) begin
         err_q   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit (WAIT_CYCLES=3, DEPTH=32).
// Driver pushes the expected response per request; a negedge monitor pops
// and compares on every response handshake.
module tb_data_mem_unit;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   data_mem_unit_if #(.ADDR_W(5)) bus ();

   data_mem_unit #(
      .DEPTH       (32),
      .WAIT_CYCLES (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endfunction

   // Monitor: compare every accepted response against the scoreboard head
   always @(negedge clk) begin
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp: rdata 0x%08h err %0d with empty scoreboard",
                     bus.rsp_rdata, bus.rsp_err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".rdata"}, bus.rsp_rdata, e.rdata);
            chk({e.tag, ".err"}, {31'h0, bus.rsp_err}, {31'h0, e.err});
         end
      end
   end

   task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [4:0] addr, input logic [31:0] wdata, input bit push,
                        input logic [31:0] er, input logic ee, input string tag);
      int t = 0;
      while (!bus.req_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!bus.req_ready) begin
         n_chk++; n_fail++;
         $display("FAIL %s.req_ready_timeout: got 0, expected 1", tag);
         return;
      end
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      if (push) exp_q.push_back('{rdata: er, err: ee, tag: tag});
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      int t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (exp_q.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL %s.rsp_timeout: %0d responses outstanding, expected 0", tag, exp_q.size());
         exp_q.delete();
      end else begin
         chk({tag, ".valid_pulse"}, {31'h0, bus.rsp_valid}, 32'h0);
      end
   endtask

   task automatic txn(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [4:0] addr, input logic [31:0] wdata,
                      input logic [31:0] er, input logic ee, input string tag);
      issue(we, size, sgn, addr, wdata, 1'b1, er, ee, tag);
      wait_rsp(tag);
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.rsp_ready  = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst.req_ready_in_reset", {31'h0, bus.req_ready}, 32'h0);
      reset = 1'b0;
      #1;
      chk("rst.req_ready", {31'h0, bus.req_ready}, 32'h1);
      chk("rst.rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      chk("rst.rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst.rsp_err",   {31'h0, bus.rsp_err}, 32'h0);

      // word store then loads of every size/extension
      txn(1, 2'b10, 0, 5'h08, 32'hDEADBEEF, 32'h0,        0, "st_w08");
      txn(0, 2'b10, 0, 5'h08, 32'h0,        32'hDEADBEEF, 0, "ld_w08");
      txn(0, 2'b10, 1, 5'h08, 32'h0,        32'hDEADBEEF, 0, "ld_w08_sgn");
      txn(0, 2'b00, 1, 5'h08, 32'h0,        32'hFFFFFFDE, 0, "ld_bs08");
      txn(0, 2'b01, 0, 5'h0A, 32'h0,        32'h0000BEEF, 0, "ld_hu0A");
      txn(0, 2'b01, 1, 5'h0A, 32'h0,        32'hFFFFBEEF, 0, "ld_hs0A");
      txn(0, 2'b00, 0, 5'h0B, 32'h0,        32'h000000EF, 0, "ld_bu0B");
      txn(0, 2'b00, 1, 5'h0B, 32'h0,        32'hFFFFFFEF, 0, "ld_bs0B");

      // byte and half stores use only the low bytes of wdata
      txn(1, 2'b00, 0, 5'h09, 32'hAABBCC7F, 32'h0,        0, "st_b09");
      txn(0, 2'b10, 0, 5'h08, 32'h0,        32'hDE7FBEEF, 0, "ld_w08_b");
      txn(1, 2'b01, 0, 5'h0A, 32'hAAAA1234, 32'h0,        0, "st_h0A");
      txn(0, 2'b10, 0, 5'h08, 32'h0,        32'hDE7F1234, 0, "ld_w08_h");

      // misaligned accesses
      txn(1, 2'b10, 0, 5'h04, 32'h11223344, 32'h0, 0, "st_w04");
      txn(1, 2'b10, 0, 5'h06, 32'hCAFEF00D, 32'h0, ALIGN, "st_w06_misal");
      txn(0, 2'b10, 0, 5'h04, 32'h0, ALIGN ? 32'h11223344 : 32'hCAFEF00D, 0, "ld_w04");
      txn(0, 2'b10, 0, 5'h08, 32'h0, 32'hDE7F1234, 0, "ld_w08_untouched");
      txn(0, 2'b01, 0, 5'h05, 32'h0, ALIGN ? 32'h0 : (ALIGN ? 32'h0 : 32'h0000CAFE), ALIGN, "ld_h05_misal");

      // reserved size: error, zero data, no write
      txn(1, 2'b10, 0, 5'h0C, 32'h01020304, 32'h0, 0, "st_w0C");
      txn(1, 2'b11, 0, 5'h0C, 32'hFFFFFFFF, 32'h0, 1, "st_rsvd");
      txn(0, 2'b11, 1, 5'h0C, 32'h0,        32'h0, 1, "ld_rsvd");
      txn(0, 2'b10, 0, 5'h0C, 32'h0, 32'h01020304, 0, "ld_w0C_after_rsvd");

      // latency and back-pressure: accept at edge N, valid after N+4
      bus.rsp_ready = 1'b0;
      issue(0, 2'b10, 0, 5'h0C, 32'h0, 1'b1, 32'h01020304, 0, "ld_w0C_stall");
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("lat.valid_low_N+%0d", k), {31'h0, bus.rsp_valid}, 32'h0);
         chk($sformatf("lat.req_ready_N+%0d", k), {31'h0, bus.req_ready}, 32'h0);
      end
      @(posedge clk); #1;
      chk("lat.valid_high_N+4", {31'h0, bus.rsp_valid}, 32'h1);
      // a request offered during the stall must be ignored
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'b10;
      bus.req_addr  = 5'h0C;
      bus.req_wdata = 32'hFFFFFFFF;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("stall.valid_%0d", k), {31'h0, bus.rsp_valid}, 32'h1);
         chk($sformatf("stall.rdata_%0d", k), bus.rsp_rdata, 32'h01020304);
         chk($sformatf("stall.req_ready_%0d", k), {31'h0, bus.req_ready}, 32'h0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      wait_rsp("ld_w0C_stall");
      txn(0, 2'b10, 0, 5'h0C, 32'h0, 32'h01020304, 0, "ld_w0C_ignored_req");

      // reset one cycle into BUSY abandons the store
      txn(1, 2'b10, 0, 5'h10, 32'h0A0B0C0D, 32'h0, 0, "st_w10");
      issue(1, 2'b10, 0, 5'h10, 32'h12345678, 1'b0, 32'h0, 0, "st_w10_abandon");
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("busy_rst.req_ready_in_reset", {31'h0, bus.req_ready}, 32'h0);
      reset = 1'b0;
      #1;
      chk("busy_rst.rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      chk("busy_rst.req_ready", {31'h0, bus.req_ready}, 32'h1);
      repeat (6) @(posedge clk);
      #1;
      chk("busy_rst.no_late_rsp", {31'h0, bus.rsp_valid}, 32'h0);
      txn(0, 2'b10, 0, 5'h10, 32'h0, 32'h0A0B0C0D, 0, "ld_w10_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
